btn_pulse_gen: RTL and testbench

BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

---
 rtl/btn_pulse_gen.sv | 182 ++++++++++++++++++
 tb/tb_btn_pulse_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_pulse_gen.sv
// Four debounced push-button channels with auto-repeat, paired-conflict
// suppression and an output enable. One FSM and counter per button.

module btn_pulse_chan #(
  parameter int DEB_CYCLES    = 50000,
  parameter int REPEAT_DELAY  = 250000,
  parameter int REPEAT_PERIOD = 100000,
  parameter int CW            = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);
  typedef enum logic [2:0] {
    IDLE, PRESS_DEB, HELD_DELAY, HELD_REPEAT, REL_DEB
  } state_t;

  localparam logic [CW:0] DEB_W = (CW+1)'(DEB_CYCLES);
  localparam logic [CW:0] RD_W  = (CW+1)'(REPEAT_DELAY);
  localparam logic [CW:0] RP_W  = (CW+1)'(REPEAT_PERIOD);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [CW:0]     cnt_ext, cnt_nxt;
  logic            sync1_q, sync1_d, sync2_q, sync2_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Increment holds at all-ones so a stuck state can never wrap the count.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign cnt_ext = {1'b0, cnt_q};
  assign cnt_nxt = cnt_ext + 1'b1;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_DEB;
          cnt_d   = CW'(1);
        end
      end
      PRESS_DEB: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_ext >= DEB_W) begin
          state_d = HELD_DELAY;
          cnt_d   = '0;
          pulse   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD_DELAY: begin
        if (!sync2_q) begin
          state_d = REL_DEB;
          cnt_d   = CW'(1);
        end else if (cnt_nxt >= RD_W) begin
          state_d = HELD_REPEAT;
          cnt_d   = '0;
          pulse   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD_REPEAT: begin
        if (!sync2_q) begin
          state_d = REL_DEB;
          cnt_d   = CW'(1);
        end else if (cnt_nxt >= RP_W) begin
          cnt_d = '0;
          pulse = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REL_DEB: begin
        // A bounce back high resumes repeating without an extra pulse.
        if (sync2_q) begin
          state_d = HELD_REPEAT;
          cnt_d   = '0;
        end else if (cnt_ext >= DEB_W) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

module btn_pulse_gen #(
  parameter int DEB_CYCLES    = 50000,
  parameter int REPEAT_DELAY  = 250000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic btn_left_x,
  input  logic btn_right_x,
  input  logic btn_left_aim,
  input  logic btn_right_aim,
  output logic left_x,
  output logic right_x,
  output logic left_aim,
  output logic right_aim
);
  localparam int MAX_A = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW    = $clog2(MAX_P + 1);

  logic [3:0] raw, pulse;
  logic left_x_q, left_x_d, right_x_q, right_x_d;
  logic left_aim_q, left_aim_d, right_aim_q, right_aim_d;

  assign raw = {btn_right_aim, btn_left_aim, btn_right_x, btn_left_x};

  for (genvar i = 0; i < 4; i++) begin : g_chan
    btn_pulse_chan #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .CW           (CW)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .btn_raw(raw[i]),
      .pulse  (pulse[i])
    );
  end

  // Opposing pulses in the same cycle cancel; en masks without stalling the FSMs.
  always_comb begin
    left_x_d    = en & pulse[0] & ~pulse[1];
    right_x_d   = en & pulse[1] & ~pulse[0];
    left_aim_d  = en & pulse[2] & ~pulse[3];
    right_aim_d = en & pulse[3] & ~pulse[2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      left_x_q    <= 1'b0;
      right_x_q   <= 1'b0;
      left_aim_q  <= 1'b0;
      right_aim_q <= 1'b0;
    end else begin
      left_x_q    <= left_x_d;
      right_x_q   <= right_x_d;
      left_aim_q  <= left_aim_d;
      right_aim_q <= right_aim_d;
    end
  end

  assign left_x    = left_x_q;
  assign right_x   = right_x_q;
  assign left_aim  = left_aim_q;
  assign right_aim = right_aim_q;
endmodule

// File: tb/tb_btn_pulse_gen.sv
// Bench for btn_pulse_gen: directed scenarios plus random button activity,
// all checked against a run-length / event-time model of the button rules.

module tb_btn_pulse_gen;
  localparam int DEB = 4;
  localparam int RD  = 16;
  localparam int RP  = 8;

  logic clk = 1'b0;
  logic reset, en;
  logic [3:0] btn;   // 0 left_x, 1 right_x, 2 left_aim, 3 right_aim
  logic left_x, right_x, left_aim, right_aim;
  logic [3:0] dout;

  int total = 0;
  int bad = 0;

  // Reference model: raw samples delayed two edges, then per-channel mode
  // 0 released, 1 held (pulse when time hits nxt), 2 releasing.
  int d1[4], d2[4], r1[4], r0[4], mode[4], nxt[4];
  bit mp[4];
  logic [3:0] exp_o;
  int t = 0;

  always #5 clk = ~clk;

  btn_pulse_gen #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .en(en),
    .btn_left_x(btn[0]), .btn_right_x(btn[1]),
    .btn_left_aim(btn[2]), .btn_right_aim(btn[3]),
    .left_x(left_x), .right_x(right_x), .left_aim(left_aim), .right_aim(right_aim)
  );

  assign dout = {right_aim, left_aim, right_x, left_x};

  task automatic tick();
    int s;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        d1[i] = 0; d2[i] = 0; r1[i] = 0; r0[i] = 0; mode[i] = 0; nxt[i] = 0; mp[i] = 0;
      end
      exp_o = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        s = d2[i];
        mp[i] = 0;
        if (s != 0) begin r1[i]++; r0[i] = 0; end
        else begin r0[i]++; r1[i] = 0; end
        case (mode[i])
          0: if (s != 0 && r1[i] == DEB + 1) begin
               mp[i] = 1; mode[i] = 1; nxt[i] = t + RD;
             end
          1: if (s == 0) mode[i] = 2;
             else if (t == nxt[i]) begin mp[i] = 1; nxt[i] = t + RP; end
          default: if (s != 0) begin mode[i] = 1; nxt[i] = t + RP; end
                   else if (r0[i] == DEB + 1) mode[i] = 0;
        endcase
        d2[i] = d1[i];
        d1[i] = int'(btn[i]);
      end
      for (int i = 0; i < 4; i++) exp_o[i] = en & mp[i] & ~mp[i ^ 1];
    end
    t++;
    #1;
  endtask

  task automatic settle(input int n);
    btn = '0; en = 1'b1; reset = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; btn = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (dout !== 4'b0000) begin
        bad++; $display("FAIL reset k=%0d got=%b exp=0000", k, dout);
      end
    end
    reset = 1'b0; btn = '0;
    settle(10);
  endtask

  task automatic test_single();
    int q[$];
    btn[0] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k == 10) btn[0] = 1'b0;
      tick();
      total++;
      if (dout !== exp_o) begin bad++; $display("FAIL single k=%0d got=%b exp=%b", k, dout, exp_o); end
      if (dout[0]) q.push_back(k);
    end
    total++;
    if (q.size() != 1 || q[0] != 6) begin
      bad++; $display("FAIL single_time n=%0d first=%0d exp n=1 at 6", q.size(), (q.size() > 0) ? q[0] : -1);
    end
    settle(12);
  endtask

  task automatic test_bounce();
    int q[$];
    for (int k = 0; k < 32; k++) begin
      btn[3] = (k < 8) ? ((k % 2) == 0) : (k < 26);
      tick();
      total++;
      if (dout !== exp_o) begin bad++; $display("FAIL bounce k=%0d got=%b exp=%b", k, dout, exp_o); end
      if (dout[3]) q.push_back(k);
    end
    total++;
    if (q.size() != 1 || q[0] != 14) begin
      bad++; $display("FAIL bounce_time n=%0d first=%0d exp n=1 at 14", q.size(), (q.size() > 0) ? q[0] : -1);
    end
    settle(12);
  endtask

  task automatic test_repeat();
    int q[$];
    int e[5] = '{6, 22, 30, 38, 46};
    bit ok;
    btn[2] = 1'b1;
    for (int k = 0; k < 70; k++) begin
      if (k == 50) btn[2] = 1'b0;
      tick();
      total++;
      if (dout !== exp_o) begin bad++; $display("FAIL repeat k=%0d got=%b exp=%b", k, dout, exp_o); end
      if (dout[2]) q.push_back(k);
    end
    ok = (q.size() == 5);
    for (int i = 0; i < 5; i++) if (ok && q[i] != e[i]) ok = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL repeat_times n=%0d exp n=5 at 6,22,30,38,46", q.size()); end
    settle(12);
  endtask

  task automatic test_conflict();
    int q[$];
    int xs = 0;
    btn[0] = 1'b1; btn[1] = 1'b1; btn[2] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 30) btn = '0;
      tick();
      total++;
      if (dout !== exp_o) begin bad++; $display("FAIL conflict k=%0d got=%b exp=%b", k, dout, exp_o); end
      if (dout[0] || dout[1]) xs++;
      if (dout[2]) q.push_back(k);
    end
    total++;
    if (xs != 0) begin bad++; $display("FAIL conflict_x pulses=%0d exp=0", xs); end
    total++;
    if (q.size() == 0 || q[0] != 6) begin
      bad++; $display("FAIL conflict_aim first=%0d exp=6", (q.size() > 0) ? q[0] : -1);
    end
    settle(12);
  endtask

  task automatic test_reset_mid();
    int q[$];
    int e[4] = '{6, 22, 30, 45};
    bit ok;
    btn[0] = 1'b1;
    for (int k = 0; k < 62; k++) begin
      reset = (k == 38);
      if (k == 50) btn[0] = 1'b0;
      tick();
      total++;
      if (dout !== exp_o) begin bad++; $display("FAIL reset_mid k=%0d got=%b exp=%b", k, dout, exp_o); end
      if (k == 38) begin
        total++;
        if (dout[0] !== 1'b0) begin bad++; $display("FAIL reset_mid_zero got=%b exp=0", dout[0]); end
      end
      if (dout[0]) q.push_back(k);
    end
    reset = 1'b0;
    ok = (q.size() == 4);
    for (int i = 0; i < 4; i++) if (ok && q[i] != e[i]) ok = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL reset_mid_times n=%0d exp n=4 at 6,22,30,45", q.size()); end
    settle(12);
  endtask

  task automatic test_enable();
    int q[$];
    btn[1] = 1'b1;
    for (int k = 0; k < 36; k++) begin
      en = (k > 10);
      if (k == 25) btn[1] = 1'b0;
      tick();
      total++;
      if (dout !== exp_o) begin bad++; $display("FAIL enable k=%0d got=%b exp=%b", k, dout, exp_o); end
      if (dout[1]) q.push_back(k);
    end
    total++;
    if (q.size() != 1 || q[0] != 22) begin
      bad++; $display("FAIL enable_time n=%0d first=%0d exp n=1 at 22", q.size(), (q.size() > 0) ? q[0] : -1);
    end
    settle(12);
  endtask

  task automatic test_random();
    int errs = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(15) == 0) btn[i] = ~btn[i];
      en = ($urandom_range(9) != 0);
      reset = ($urandom_range(399) == 0);
      tick();
      total++;
      if (dout !== exp_o) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL random k=%0d got=%b exp=%b", k, dout, exp_o);
      end
    end
    settle(12);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; btn = '0;
    test_reset();
    test_single();
    test_bounce();
    test_repeat();
    test_conflict();
    test_reset_mid();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
